sram_access_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single external 16-bit SRAM. It shares the SRAM between the display read port (VGA frame fetch, high priority) and the game-logic write port (sprite/frame updates). It sits between `top`'s datapath and the `SRAM_*` pins, in the 108 MHz domain. It owns all SRAM control strobes and the DQ tri-state enable.

---
 rtl/sram_access_arbiter.sv | 164 ++++++++++++++++
 tb/tb_sram_access_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter: shares the single external 16-bit SRAM between the
// display read port (high priority) and the game-logic write port. Owns all
// SRAM strobes and the DQ output enable; every SRAM-facing output is a flop.
module sram_access_arbiter #(
    parameter int ADDR_W       = 20,
    parameter int DATA_W       = 16,
    parameter int ACC_CYC      = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_rd_ack,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    input  logic              i_wr_req,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ack,
    output logic [ADDR_W-1:0] o_SRAM_ADDR,
    output logic [DATA_W-1:0] o_SRAM_DQ,
    output logic              o_SRAM_DQ_OE,
    input  logic [DATA_W-1:0] i_SRAM_DQ,
    output logic              o_SRAM_WE_N,
    output logic              o_SRAM_OE_N,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE
    } state_t;

    // Cycle index of the final access cycle, and of the last cycle with WE low.
    localparam logic [3:0] CYC_LAST   = 4'(ACC_CYC - 1);
    localparam logic [3:0] WE_LAST    = 4'(ACC_CYC - 2);
    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    state_t            state_q, state_d;
    logic [3:0]        cyc_q, cyc_d;
    logic [7:0]        starve_q, starve_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dq_q, dq_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              we_n_q, we_n_d;
    logic              oe_n_q, oe_n_d;
    logic              dq_oe_q, dq_oe_d;
    logic              rd_ack, wr_ack;
    logic              wr_wins;

    // Grant decision in IDLE plus access sequencing; the strobes for the next
    // cycle are computed here so that the SRAM pins come straight from flops.
    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        starve_d   = starve_q;
        addr_d     = addr_q;
        dq_d       = dq_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        we_n_d     = we_n_q;
        oe_n_d     = oe_n_q;
        dq_oe_d    = dq_oe_q;
        rd_ack     = 1'b0;
        wr_ack     = 1'b0;
        wr_wins    = i_wr_req && (!i_rd_req || (starve_q == STARVE_MAX));

        case (state_q)
            ST_IDLE: begin
                if (!i_rst && wr_wins) begin
                    wr_ack   = 1'b1;
                    state_d  = ST_WRITE;
                    cyc_d    = 4'd0;
                    addr_d   = i_wr_addr;
                    dq_d     = i_wr_data;
                    we_n_d   = 1'b0;
                    dq_oe_d  = 1'b1;
                    starve_d = 8'd0;
                end else if (!i_rst && i_rd_req) begin
                    rd_ack  = 1'b1;
                    state_d = ST_READ;
                    cyc_d   = 4'd0;
                    addr_d  = i_rd_addr;
                    oe_n_d  = 1'b0;
                    if (!i_wr_req) begin
                        starve_d = 8'd0;
                    end else if (starve_q < STARVE_MAX) begin
                        starve_d = starve_q + 8'd1;
                    end
                end
            end
            ST_READ: begin
                if (cyc_q == CYC_LAST) begin
                    state_d    = ST_IDLE;
                    oe_n_d     = 1'b1;
                    rd_data_d  = i_SRAM_DQ;
                    rd_valid_d = 1'b1;
                end else begin
                    cyc_d = cyc_q + 4'd1;
                end
            end
            ST_WRITE: begin
                if (cyc_q == CYC_LAST) begin
                    state_d = ST_IDLE;
                    dq_oe_d = 1'b0;
                    we_n_d  = 1'b1;
                end else begin
                    cyc_d = cyc_q + 4'd1;
                    if (cyc_q == WE_LAST) begin
                        we_n_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                we_n_d  = 1'b1;
                oe_n_d  = 1'b1;
                dq_oe_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            cyc_q      <= 4'd0;
            starve_q   <= 8'd0;
            addr_q     <= '0;
            dq_q       <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            we_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            dq_oe_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            starve_q   <= starve_d;
            addr_q     <= addr_d;
            dq_q       <= dq_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            we_n_q     <= we_n_d;
            oe_n_q     <= oe_n_d;
            dq_oe_q    <= dq_oe_d;
        end
    end

    assign o_rd_ack     = rd_ack;
    assign o_wr_ack     = wr_ack;
    assign o_rd_data    = rd_data_q;
    assign o_rd_valid   = rd_valid_q;
    assign o_SRAM_ADDR  = addr_q;
    assign o_SRAM_DQ    = dq_q;
    assign o_SRAM_DQ_OE = dq_oe_q;
    assign o_SRAM_WE_N  = we_n_q;
    assign o_SRAM_OE_N  = oe_n_q;
    assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sram_access_arbiter.sv
// tb_sram_access_arbiter: directed vector table, hand-written corner-case
// sequences and a randomized run against a transaction-level reference model.
module tb_sram_access_arbiter;

    localparam int ADDR_W       = 20;
    localparam int DATA_W       = 16;
    localparam int ACC_CYC      = 2;
    localparam int STARVE_LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_req = 1'b0;
    logic [19:0] rd_addr = '0;
    logic        rd_ack;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        wr_req = 1'b0;
    logic [19:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        wr_ack;
    logic [19:0] sram_addr;
    logic [15:0] sram_dq_o;
    logic        dq_oe;
    logic [15:0] sram_dq_i = 16'hDEAD;
    logic        we_n;
    logic        oe_n;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [15:0] sram_mem [logic [19:0]];
    logic [15:0] ref_mem  [logic [19:0]];
    logic        we_n_prev = 1'b1;

    typedef struct {
        logic        rd;
        logic [19:0] ra;
        logic        wr;
        logic [19:0] wa;
        logic [15:0] wd;
        logic [6:0]  e_flags;
        logic [15:0] e_data;
        logic [19:0] e_addr;
        logic [15:0] e_dq;
    } vec_t;

    vec_t vecs[$];

    sram_access_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACC_CYC(ACC_CYC), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_ack(rd_ack),
        .o_rd_data(rd_data), .o_rd_valid(rd_valid),
        .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ack(wr_ack),
        .o_SRAM_ADDR(sram_addr), .o_SRAM_DQ(sram_dq_o), .o_SRAM_DQ_OE(dq_oe),
        .i_SRAM_DQ(sram_dq_i), .o_SRAM_WE_N(we_n), .o_SRAM_OE_N(oe_n), .o_busy(busy)
    );

    // 108 MHz stand-in clock
    always #5 clk = ~clk;

    // Contents of never-written SRAM locations
    function automatic logic [15:0] fill_pattern(input logic [19:0] a);
        if (a == 20'h12345) return 16'hBEEF;
        return a[15:0] ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] expData(input logic [19:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return fill_pattern(a);
    endfunction

    // SRAM pin model: latches on the WE rising edge, drives DQ while OE is low
    always @(negedge clk) begin
        if (we_n_prev == 1'b0 && we_n == 1'b1 && dq_oe) sram_mem[sram_addr] = sram_dq_o;
        we_n_prev = we_n;
        if (!oe_n) sram_dq_i = sram_mem.exists(sram_addr) ? sram_mem[sram_addr] : fill_pattern(sram_addr);
        else       sram_dq_i = 16'hDEAD;
    end

    // Watchdog so the run can never hang
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic rd, input logic [19:0] ra, input logic wr,
                                 input logic [19:0] wa, input logic [15:0] wd);
        rd_req  = rd;
        rd_addr = ra;
        wr_req  = wr;
        wr_addr = wa;
        wr_data = wd;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic addRow(input logic rd, input logic [19:0] ra, input logic wr, input logic [19:0] wa,
                          input logic [15:0] wd, input logic [6:0] fl, input logic [15:0] d,
                          input logic [19:0] a, input logic [15:0] q);
        vec_t v;
        v.rd = rd; v.ra = ra; v.wr = wr; v.wa = wa; v.wd = wd;
        v.e_flags = fl; v.e_data = d; v.e_addr = a; v.e_dq = q;
        vecs.push_back(v);
    endtask

    function automatic logic [6:0] flags();
        return {rd_ack, wr_ack, busy, oe_n, we_n, dq_oe, rd_valid};
    endfunction

    initial begin
        int rd_acks;
        logic got_wr;
        int n_acks, n_valid, last_ack;
        logic ack_seen, we_low, seen;
        int free_at, valid_at, starve;
        logic e_wr, e_rd, free;
        logic [15:0] pend_data, exp_data;
        logic prev_rd_ack, prev_wr_ack;

        // flags = {rd_ack, wr_ack, busy, oe_n, we_n, dq_oe, rd_valid}
        addRow(0, 20'h0,     0, 20'h0,  16'h0,    7'b0001100, 16'h0000, 20'h00000, 16'h0000);
        addRow(1, 20'h12345, 0, 20'h0,  16'h0,    7'b1001100, 16'h0000, 20'h00000, 16'h0000);
        addRow(0, 20'h0,     0, 20'h0,  16'h0,    7'b0010100, 16'h0000, 20'h12345, 16'h0000);
        addRow(0, 20'h0,     0, 20'h0,  16'h0,    7'b0010100, 16'h0000, 20'h12345, 16'h0000);
        addRow(0, 20'h0,     0, 20'h0,  16'h0,    7'b0001101, 16'hBEEF, 20'h12345, 16'h0000);
        addRow(0, 20'h0,     0, 20'h0,  16'h0,    7'b0001100, 16'hBEEF, 20'h12345, 16'h0000);
        addRow(0, 20'h0,     1, 20'h10, 16'hA5A5, 7'b0101100, 16'hBEEF, 20'h12345, 16'h0000);
        addRow(0, 20'h0,     0, 20'h0,  16'h0,    7'b0011010, 16'hBEEF, 20'h00010, 16'hA5A5);
        addRow(0, 20'h0,     0, 20'h0,  16'h0,    7'b0011110, 16'hBEEF, 20'h00010, 16'hA5A5);
        addRow(0, 20'h0,     0, 20'h0,  16'h0,    7'b0001100, 16'hBEEF, 20'h00010, 16'hA5A5);
        addRow(1, 20'h10,    0, 20'h0,  16'h0,    7'b1001100, 16'hBEEF, 20'h00010, 16'hA5A5);
        addRow(0, 20'h0,     0, 20'h0,  16'h0,    7'b0010100, 16'hBEEF, 20'h00010, 16'hA5A5);
        addRow(0, 20'h0,     0, 20'h0,  16'h0,    7'b0010100, 16'hBEEF, 20'h00010, 16'hA5A5);
        addRow(0, 20'h0,     0, 20'h0,  16'h0,    7'b0001101, 16'hA5A5, 20'h00010, 16'hA5A5);
        addRow(1, 20'h3,     1, 20'h4,  16'h1234, 7'b1001100, 16'hA5A5, 20'h00010, 16'hA5A5);
        addRow(0, 20'h0,     1, 20'h4,  16'h1234, 7'b0010100, 16'hA5A5, 20'h00003, 16'hA5A5);
        addRow(0, 20'h0,     1, 20'h4,  16'h1234, 7'b0010100, 16'hA5A5, 20'h00003, 16'hA5A5);
        addRow(0, 20'h0,     1, 20'h4,  16'h1234, 7'b0101101, 16'h5A59, 20'h00003, 16'hA5A5);
        addRow(0, 20'h0,     0, 20'h0,  16'h0,    7'b0011010, 16'h5A59, 20'h00004, 16'h1234);
        addRow(0, 20'h0,     0, 20'h0,  16'h0,    7'b0011110, 16'h5A59, 20'h00004, 16'h1234);
        addRow(0, 20'h0,     0, 20'h0,  16'h0,    7'b0001100, 16'h5A59, 20'h00004, 16'h1234);

        // Reset values, including acks suppressed while reset is high
        applyStimulus(1, 20'h12345, 1, 20'h1, 16'h1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_flags", 32'(flags()), 32'(7'b0001100));
        checkOutput("reset_addr", 32'(sram_addr), 32'h0);
        checkOutput("reset_dq", 32'(sram_dq_o), 32'h0);
        checkOutput("reset_rd_data", 32'(rd_data), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);

        // Directed table: single read, single write, read-back, simultaneous requests
        foreach (vecs[i]) begin
            @(posedge clk); #1;
            applyStimulus(vecs[i].rd, vecs[i].ra, vecs[i].wr, vecs[i].wa, vecs[i].wd);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_flags", i), 32'(flags()), 32'(vecs[i].e_flags));
            checkOutput($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].e_data));
            checkOutput($sformatf("vec%0d_addr", i), 32'(sram_addr), 32'(vecs[i].e_addr));
            checkOutput($sformatf("vec%0d_dq", i), 32'(sram_dq_o), 32'(vecs[i].e_dq));
        end
        ref_mem[20'h00010] = 16'hA5A5;
        ref_mem[20'h00004] = 16'h1234;
        checkOutput("sram_holds_0x10", 32'(sram_mem.exists(20'h10) ? sram_mem[20'h10] : 16'h0), 32'hA5A5);

        // Starvation: both held; twice 8 reads then a write
        for (int round = 0; round < 2; round++) begin
            @(posedge clk); #1;
            applyStimulus(1, 20'h00020, 1, 20'h00300, 16'hC0DE);
            rd_acks = 0;
            got_wr  = 1'b0;
            for (int c = 0; c < 100; c++) begin
                @(negedge clk);
                if (wr_ack) begin got_wr = 1'b1; break; end
                if (rd_ack) rd_acks++;
                @(posedge clk); #1;
            end
            checkOutput($sformatf("starve%0d_write_granted", round), 32'(got_wr), 32'h1);
            checkOutput($sformatf("starve%0d_read_count", round), 32'(rd_acks), 32'd8);
        end
        @(posedge clk); #1;
        applyStimulus(0, 0, 0, 0, 0);
        repeat (4) @(posedge clk);
        #1;

        // Reset in the middle of a write
        applyStimulus(0, 0, 1, 20'h00400, 16'h7777);
        @(negedge clk);
        checkOutput("rstw_ack", 32'(wr_ack), 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("rstw_we_active", 32'(we_n), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstw_after_flags", 32'(flags()), 32'(7'b0001100));
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (rd_ack || wr_ack || rd_valid || busy) seen = 1'b1;
        end
        checkOutput("rstw_quiet", 32'(seen), 32'h0);

        // Reset in the middle of a read
        @(posedge clk); #1;
        applyStimulus(1, 20'h12345, 0, 0, 0);
        @(negedge clk);
        checkOutput("rstr_ack", 32'(rd_ack), 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("rstr_oe_active", 32'(oe_n), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (rd_ack || wr_ack || rd_valid || busy || !oe_n) seen = 1'b1;
            @(posedge clk); #1;
        end
        checkOutput("rstr_quiet", 32'(seen), 32'h0);
        checkOutput("rstr_rd_data", 32'(rd_data), 32'h0);

        // Back-to-back reads from addresses 0..15
        applyStimulus(1, 20'h0, 0, 0, 0);
        n_acks = 0; n_valid = 0; last_ack = -1; we_low = 1'b0;
        for (int c = 0; c < 200 && n_valid < 16; c++) begin
            @(negedge clk);
            if (!we_n) we_low = 1'b1;
            if (rd_valid) begin
                checkOutput($sformatf("b2b_data%0d", n_valid), 32'(rd_data), 32'(expData(20'(n_valid))));
                n_valid++;
            end
            ack_seen = rd_ack;
            if (rd_ack) begin
                if (last_ack >= 0) checkOutput("b2b_ack_period", 32'(c - last_ack), 32'd3);
                last_ack = c;
                n_acks++;
            end
            @(posedge clk); #1;
            if (ack_seen) begin
                if (n_acks < 16) rd_addr = 20'(n_acks);
                else rd_req = 1'b0;
            end
        end
        checkOutput("b2b_ack_count", 32'(n_acks), 32'd16);
        checkOutput("b2b_valid_count", 32'(n_valid), 32'd16);
        checkOutput("b2b_we_never_low", 32'(we_low), 32'h0);

        // Randomized traffic against the transaction-level model
        applyStimulus(0, 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        free_at = 0; valid_at = -1; starve = 0;
        pend_data = '0; exp_data = '0;
        prev_rd_ack = 1'b0; prev_wr_ack = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!rd_req || prev_rd_ack) begin
                if ($urandom_range(2) != 0) begin
                    rd_req  = 1'b1;
                    rd_addr = 20'h40 + 20'($urandom_range(7));
                end else rd_req = 1'b0;
            end else if ($urandom_range(15) == 0) rd_req = 1'b0;
            if (!wr_req || prev_wr_ack) begin
                if ($urandom_range(2) != 0) begin
                    wr_req  = 1'b1;
                    wr_addr = 20'h40 + 20'($urandom_range(7));
                    wr_data = 16'($urandom);
                end else wr_req = 1'b0;
            end else if ($urandom_range(15) == 0) wr_req = 1'b0;

            @(negedge clk);
            free = (c >= free_at);
            e_wr = free && wr_req && (!rd_req || starve == STARVE_LIMIT);
            e_rd = free && rd_req && !e_wr;
            if (c == valid_at) exp_data = pend_data;
            checkOutput($sformatf("rnd_rd_ack@%0d", c), 32'(rd_ack), 32'(e_rd));
            checkOutput($sformatf("rnd_wr_ack@%0d", c), 32'(wr_ack), 32'(e_wr));
            checkOutput($sformatf("rnd_busy@%0d", c), 32'(busy), 32'(!free));
            checkOutput($sformatf("rnd_rd_valid@%0d", c), 32'(rd_valid), 32'(c == valid_at));
            checkOutput($sformatf("rnd_rd_data@%0d", c), 32'(rd_data), 32'(exp_data));
            if (e_rd) begin
                pend_data = expData(rd_addr);
                valid_at  = c + ACC_CYC + 1;
                free_at   = c + ACC_CYC + 1;
                starve    = wr_req ? ((starve < STARVE_LIMIT) ? starve + 1 : starve) : 0;
            end
            if (e_wr) begin
                ref_mem[wr_addr] = wr_data;
                free_at = c + ACC_CYC + 1;
                starve  = 0;
            end
            prev_rd_ack = rd_ack;
            prev_wr_ack = wr_ack;
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
